frame_dump_ctrl: RTL
====================

// Module: frame_dump_ctrl
// PURPOSE
//  Sequences a debug frame dump: on a debounced trigger, reads every word of the downsample
//  buffer (x,y raster), serialises each 32-bit word MSB-byte-first and feeds the UART byte by byte.
//  Prefixes a 4-byte header for host resync. Sits between downsample (read port) and uart in top.
// PARAMETERS
//  WIDTH         40  words per row (read_x range 0..WIDTH-1)
//  HEIGHT        30  rows (read_y range 0..HEIGHT-1)
//  READ_LAT      1   cycles from read_x_o/read_y_o change to valid read_q_i
//  DEBOUNCE_BITS 14  trigger must be stable-high 2^DEBOUNCE_BITS-1 cycles
//  HOLDOFF_BITS  13  idle cycles (2^HOLDOFF_BITS-1) after uart_busy_i low before next write
// PORTS
//  sys_clk_i   in   1   system clock (12 MHz domain)
//  sys_rst_i   in   1   synchronous, active-high reset
//  trigger_i   in   1   raw button, asynchronous; 2-flop synchronised internally
//  abort_i     in   1   synchronous; ends dump after current byte
//  read_x_o    out  6   buffer column address
//  read_y_o    out  5   buffer row address
//  read_q_i    in   32  buffer read data
//  uart_busy_i in   1   UART transmitting
//  uart_wr_o   out  1   one-cycle write strobe
//  uart_dat_o  out  8   byte to send, valid while uart_wr_o high
//  busy_o      out  1   dump in progress (state != IDLE)
//  done_o      out  1   one-cycle pulse when dump completes or aborts
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, holdoff saturated, debounce 0, armed=1.
//  Trigger: debounce counter clears when synced trigger low, else counts, saturating. Start fires
//   on the cycle it reaches all-ones while armed and IDLE; armed clears, re-sets when trigger low.
//  Header bytes, in order: 0x46 ('F'), 0x44 ('D'), WIDTH[7:0], HEIGHT[7:0].
//  Write gate: uart_wr_o may assert only when holdoff all-ones, !uart_busy_i, uart_wr_o low last cycle.
//   Holdoff clears on uart_wr_o or uart_busy_i, else increments, saturating.
//  States:
//   IDLE   -> HEADER on start; hdr_idx=0, x=y=z=0.
//   HEADER : on gate, write header[hdr_idx]; after idx 3 -> FETCH.
//   FETCH  : drive read_x_o/read_y_o=(x,y); wait READ_LAT cycles; latch read_q_i -> word_r; -> SEND.
//   SEND   : on gate, write word_r byte z (z=0:[31:24] .. z=3:[7:0]); z++.
//            z wraps 3->0: x++ (x==WIDTH-1 -> x=0,y++); y==HEIGHT-1 && x==WIDTH-1 -> DONE else FETCH.
//   DONE   : done_o=1 one cycle -> IDLE.
//  Total bytes per dump: 4 + 4*WIDTH*HEIGHT (4804 at defaults).
//  Abort: sampled every cycle; in HEADER/FETCH/SEND, if no write this cycle -> DONE next cycle;
//   if write this cycle, that byte completes, then DONE. Abort in IDLE ignored.
//  Trigger during dump ignored (not queued). Abort and start same cycle in IDLE: start wins.
//  Reset mid-dump: immediate return to IDLE, uart_wr_o=0, no done_o pulse.
//  read_x_o/read_y_o hold last value in IDLE; word_r changes only on FETCH latch.
// STRUCTURE
//  Shared package frame_dump_pkg: state enum (IDLE,HEADER,FETCH,SEND,DONE), HDR_MAGIC0/1 constants.
//  One sub-module: frame_dump_debounce (sync + debounce + armed edge, outputs start pulse).
//  Holdoff counter, address counters and FSM inline.
// TESTING (bench: DEBOUNCE_BITS=3, HOLDOFF_BITS=2, WIDTH=3, HEIGHT=2, RAM model READ_LAT=1,
//  UART model busy 10 cycles from 2 cycles after write)
//  1 Trigger high 20 cycles -> exactly 4+24=28 bytes: 46,44,03,02 then words MSB-first in
//    raster order (0,0),(1,0),(2,0),(0,1)..; done_o one pulse; busy_o low after.
//  2 Trigger 5-cycle glitch (<7 stable) -> no uart_wr_o; held high 100 cycles -> single dump only.
//  3 uart_busy_i held high 50 cycles mid-dump -> no uart_wr_o while high; next write >=3 cycles
//    after busy falls; no byte dropped or repeated.
//  4 abort_i pulse during byte 10 -> byte 10 sent, done_o pulse, 10 bytes total, IDLE.
//  5 sys_rst_i during byte 15 -> uart_wr_o 0 immediately, no done_o; fresh trigger -> full 28 bytes.
//  6 RAM data changes at address change -> every byte matches word at (x,y) latched after READ_LAT.

Source files
------------

// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared state encoding and header magic bytes for the frame dump sequencer.
package frame_dump_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, FETCH, SEND, DONE} state_e;
    localparam logic [7:0] HDR_MAGIC0 = 8'h46;
    localparam logic [7:0] HDR_MAGIC1 = 8'h44;
endpackage

// File: rtl/frame_dump_debounce.sv
// frame_dump_debounce: synchronises the raw trigger, debounces it and emits a one-cycle start pulse.
module frame_dump_debounce import frame_dump_pkg::*; #(
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trigger_i,
    input  logic idle_i,
    output logic start_o
);
    logic [1:0] sync_q;
    logic [DEBOUNCE_BITS-1:0] deb_q;
    logic armed_q;
    logic full;
    assign full = &deb_q;
    assign start_o = full & armed_q & idle_i;
    // Armed drops on reaching full count even when busy, so triggers during a dump are not queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            deb_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], trigger_i};
            deb_q   <= !sync_q[1] ? '0 : full ? deb_q : deb_q + 1'b1;
            armed_q <= !sync_q[1] ? 1'b1 : full ? 1'b0 : armed_q;
        end
    end
endmodule

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: dumps the downsample buffer over the UART as a header plus MSB-first words.
module frame_dump_ctrl import frame_dump_pkg::*; #(
    parameter int WIDTH         = 40,
    parameter int HEIGHT        = 30,
    parameter int READ_LAT      = 1,
    parameter int DEBOUNCE_BITS = 14,
    parameter int HOLDOFF_BITS  = 13
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        trigger_i,
    input  logic        abort_i,
    output logic [5:0]  read_x_o,
    output logic [4:0]  read_y_o,
    input  logic [31:0] read_q_i,
    input  logic        uart_busy_i,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int LW = $clog2(READ_LAT + 2);
    state_e state_q;
    logic [HOLDOFF_BITS-1:0] hold_q;
    logic [1:0]  hdr_q, z_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [LW-1:0] lat_q;
    logic [31:0] word_q;
    logic        wr_q, done_q;
    logic [7:0]  dat_q;
    logic start, gate, active, writing, last_x, last_y;
    logic [7:0] hdr_byte, word_byte;
    frame_dump_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_deb (
        .clk_i    (sys_clk_i),
        .rst_i    (sys_rst_i),
        .trigger_i(trigger_i),
        .idle_i   (state_q == IDLE),
        .start_o  (start)
    );
    always_comb begin
        gate      = (&hold_q) & !uart_busy_i & !wr_q;
        active    = state_q == HEADER || state_q == FETCH || state_q == SEND;
        writing   = gate && (state_q == HEADER || state_q == SEND);
        last_x    = x_q == 6'(WIDTH - 1);
        last_y    = y_q == 5'(HEIGHT - 1);
        hdr_byte  = hdr_q == 2'd0 ? HDR_MAGIC0 : hdr_q == 2'd1 ? HDR_MAGIC1 :
                    hdr_q == 2'd2 ? 8'(WIDTH) : 8'(HEIGHT);
        word_byte = 8'(word_q >> {~z_q, 3'b000});
    end
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            hold_q  <= '1;
            hdr_q   <= '0;
            z_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            lat_q   <= '0;
            word_q  <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            hold_q <= (wr_q | uart_busy_i) ? '0 : (&hold_q) ? hold_q : hold_q + 1'b1;
            wr_q   <= writing;
            done_q <= 1'b0;
            if (writing) dat_q <= state_q == HEADER ? hdr_byte : word_byte;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= HEADER;
                    hdr_q   <= '0;
                    z_q     <= '0;
                    x_q     <= '0;
                    y_q     <= '0;
                    lat_q   <= '0;
                end
                HEADER: if (gate) begin
                    hdr_q <= hdr_q + 1'b1;
                    if (hdr_q == 2'd3) state_q <= FETCH;
                end
                FETCH: if (lat_q == LW'(READ_LAT)) begin
                    word_q  <= read_q_i;
                    lat_q   <= '0;
                    state_q <= SEND;
                end else lat_q <= lat_q + 1'b1;
                SEND: if (gate) begin
                    z_q <= z_q + 1'b1;
                    if (z_q == 2'd3) begin
                        if (last_x && last_y) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            x_q     <= last_x ? '0 : x_q + 1'b1;
                            y_q     <= last_x ? y_q + 1'b1 : y_q;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A byte issued alongside abort still goes out; the dump then ends.
            if (abort_i && active) begin
                state_q <= DONE;
                done_q  <= 1'b1;
            end
        end
    end
    assign read_x_o   = x_q;
    assign read_y_o   = y_q;
    assign uart_wr_o  = wr_q;
    assign uart_dat_o = dat_q;
    assign busy_o     = state_q != IDLE;
    assign done_o     = done_q;
endmodule
